pwm_sweep_scheduler: RTL and testbench
======================================

PWM_SWEEP_SCHEDULER -- requirements
Module: pwm_sweep_scheduler

Interface
REQ-001 Parameter DWELL_W, default 16, width of dwell period count.
REQ-002 clk  input  1  system clock (20 MHz PLL output).
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 enable  input  1  level; high = run scheduler, low = park output low.
REQ-005 dwell  input  DWELL_W  periods per channel before switching; sampled on channel entry.
REQ-006 cfg_valid  input  1  config write request.
REQ-007 cfg_ready  output  1  config slot free.
REQ-008 cfg_chan  input  1  target channel (0/1).
REQ-009 cfg_mode  input  2  00 hold, 01 ramp-up wrap, 10 triangle, 11 treated as hold.
REQ-010 cfg_div  input  4  duty steps once every 2^cfg_div periods.
REQ-011 cfg_duty  input  8  starting duty.
REQ-012 pwm_out  output  1  registered PWM output.
REQ-013 period_stb  output  1  one-cycle pulse in last cycle of each 256-cycle period.
REQ-014 active_chan  output  1  channel currently driving pwm_out.
REQ-015 duty0, duty1  output  8 each  current channel duties.

Function
REQ-016 8-bit period counter cnt SHALL free-run 0..255 and wrap; "boundary" = cycle with cnt==255; period_stb = (cnt==255).
REQ-017 pwm_out SHALL be registered: next value = (state!=IDLE) && (cnt_next < duty[active_chan]); duty 0 gives constant low, duty 255 gives 255/256 high.
REQ-018 Config handshake: transfer when cfg_valid && cfg_ready; fields captured into a single shadow slot; cfg_ready SHALL drop the cycle after transfer.
REQ-019 Shadow SHALL apply at the first boundary strictly after capture (capture in a boundary cycle applies at the next boundary); cfg_ready returns high the cycle after apply.
REQ-020 Apply SHALL load duty, mode, div for cfg_chan, clear that channel's prescaler, set direction up.
REQ-021 Each channel SHALL keep a 16-bit period prescaler; at a boundary when prescaler == 2^div-1 it clears and duty steps, else it increments.
REQ-022 Step rules: hold = unchanged; ramp-up = duty+1, 255 wraps to 0; triangle = +1 while up, at 255 direction flips to down and duty becomes 254; -1 while down, at 0 flips up and becomes 1.
REQ-023 A config apply and a ramp step on the same channel at the same boundary: apply wins, no step.
REQ-024 Both channels SHALL ramp continuously in any state, including IDLE.
REQ-025 FSM states IDLE, RUN_A (active_chan=0), RUN_B (active_chan=1); all transitions only at boundaries.
REQ-026 IDLE -> RUN_A at boundary if enable; RUN_A <-> RUN_B after dwell periods elapse (dwell 0 treated as 1); any RUN -> IDLE at boundary if enable low.
REQ-027 Dwell counter SHALL load at entry to RUN_A/RUN_B and count boundaries; switch occurs on the boundary completing the dwell-th period.
REQ-028 active_chan SHALL hold its last value in IDLE.

Reset
REQ-029 On rst_n low, asynchronously: cnt=0, state IDLE, pwm_out=0, period_stb=0, active_chan=0, duty0=duty1=0, modes hold, div=0, prescalers 0, directions up, shadow empty.
REQ-030 cfg_ready SHALL be 1 in the first cycle after rst_n deasserts; reset mid-period or mid-handshake discards pending config.

Verification
REQ-031 Reset, enable=1, cfg ch0 duty=64 mode=hold, dwell=1000 -> after first boundary pwm_out high exactly 64 of every 256 cycles, active_chan=0.
REQ-032 ch0 mode=01 div=0 duty=254 -> duty0 goes 254,255,0,1 on successive boundaries.
REQ-033 ch1 mode=10 div=2 duty=253 -> duty1 steps every 4 periods: 254,255,254,253.
REQ-034 enable=1, dwell=2, both channels configured -> active_chan toggles every 512 cycles, only at boundaries; dwell=0 -> toggles every 256.
REQ-035 cfg_valid held high in a boundary cycle -> cfg_ready low, duty applied 256 cycles later; second write waits until cfg_ready=1.
REQ-036 Drop enable mid-period -> pwm_out continues to period end, then 0 from cnt=0; assert rst_n low mid-period -> all outputs 0 immediately.

Source files
------------

// File: rtl/pwm_sweep_scheduler.sv
// -----------------------------------------------------------------------------
// pwm_sweep_scheduler
//
// Two-channel PWM sweep generator with a time-sliced output. A free-running
// 8-bit counter defines 256-cycle PWM periods. Each channel owns a duty value
// that can hold, ramp upward with wrap, or sweep as a triangle, stepping once
// every 2^div periods. A scheduler FSM picks which channel drives pwm_out and
// alternates between them after a programmable number of periods (dwell).
// Configuration arrives through a one-slot valid/ready shadow register and is
// applied only at period boundaries so a running waveform is never torn.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   enable       level: 1 = schedule channels onto pwm_out, 0 = park output low
//   dwell        periods per channel before switching (0 behaves as 1),
//                sampled when a channel is entered
//   cfg_valid    configuration write request
//   cfg_ready    shadow slot is free (a write is accepted on valid && ready)
//   cfg_chan     target channel of the write
//   cfg_mode     00 hold, 01 ramp-up with wrap, 10 triangle, 11 hold
//   cfg_div      duty steps once every 2^cfg_div periods
//   cfg_duty     starting duty loaded on apply
//   pwm_out      registered PWM output
//   period_stb   high during the last cycle (cnt == 255) of every period
//   active_chan  channel currently driving pwm_out (held while idle)
//   duty0/duty1  current duty of channel 0 / channel 1
// -----------------------------------------------------------------------------
module pwm_sweep_scheduler #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic               cfg_chan,
  input  logic [1:0]         cfg_mode,
  input  logic [3:0]         cfg_div,
  input  logic [7:0]         cfg_duty,
  output logic               pwm_out,
  output logic               period_stb,
  output logic               active_chan,
  output logic [7:0]         duty0,
  output logic [7:0]         duty1
);

  // ---------------------------------------------------------------------------
  // Types
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    MODE_HOLD     = 2'b00,
    MODE_RAMP     = 2'b01,
    MODE_TRI      = 2'b10,
    MODE_HOLD_ALT = 2'b11   // reserved encoding, behaves exactly like hold
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN_A = 2'b01,
    ST_RUN_B = 2'b10
  } state_e;

  // Per-channel sweep state.
  typedef struct packed {
    logic [7:0]  duty;
    mode_e       mode;
    logic [3:0]  div;
    logic [15:0] presc;  // periods elapsed since the last duty step
    logic        down;   // triangle direction, 0 = counting up
  } chan_t;

  // Contents of the configuration shadow slot.
  typedef struct packed {
    logic       chan;
    mode_e      mode;
    logic [3:0] div;
    logic [7:0] duty;
  } cfg_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // Terminal prescaler count for a given divider: 2^div - 1 (max 0x7FFF).
  function automatic logic [15:0] presc_max(input logic [3:0] div);
    return (16'd1 << div) - 16'd1;
  endfunction

  // One duty step according to the channel's mode. The triangle reverses at
  // the rails and immediately moves one step away, so 255 and 0 each occupy
  // a single step of the sweep.
  function automatic chan_t step_duty(input chan_t c);
    chan_t r;
    r = c;
    case (c.mode)
      MODE_RAMP: r.duty = c.duty + 8'd1;
      MODE_TRI: begin
        if (!c.down) begin
          if (c.duty == 8'hFF) begin
            r.down = 1'b1;
            r.duty = 8'hFE;
          end else begin
            r.duty = c.duty + 8'd1;
          end
        end else begin
          if (c.duty == 8'h00) begin
            r.down = 1'b0;
            r.duty = 8'h01;
          end else begin
            r.duty = c.duty - 8'd1;
          end
        end
      end
      default: r.duty = c.duty;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------
  logic [7:0]         cnt;
  logic [7:0]         cnt_d;
  logic               boundary;

  chan_t              ch_q [2];
  chan_t              ch_d [2];

  cfg_t               shadow;
  logic               shadow_full;
  logic               apply;

  state_e             state;
  state_e             state_d;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DWELL_W-1:0] dwell_cnt_d;
  logic [DWELL_W-1:0] dwell_load;
  logic               chan_d;
  logic               pwm_d;

  // ---------------------------------------------------------------------------
  // Period counter and simple decodes
  // ---------------------------------------------------------------------------
  assign cnt_d      = cnt + 8'd1;         // wraps 255 -> 0 naturally
  assign boundary   = (cnt == 8'hFF);
  assign period_stb = boundary;
  assign cfg_ready  = ~shadow_full;

  // The slot is examined only at a boundary, so a write captured on the
  // boundary edge itself waits for the following boundary.
  assign apply = boundary & shadow_full;

  assign duty0 = ch_q[0].duty;
  assign duty1 = ch_q[1].duty;

  // Dwell counter counts down to zero; a programmed 0 behaves as 1.
  assign dwell_load = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Channel sweep next-state
  // ---------------------------------------------------------------------------
  // Channels advance in every scheduler state, including idle. A pending
  // configuration for a channel replaces that channel's step at the same
  // boundary.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      ch_d[c] = ch_q[c];
      if (boundary) begin
        if (apply && (shadow.chan == 1'(c))) begin
          ch_d[c].duty  = shadow.duty;
          ch_d[c].mode  = shadow.mode;
          ch_d[c].div   = shadow.div;
          ch_d[c].presc = 16'd0;
          ch_d[c].down  = 1'b0;
        end else if (ch_q[c].presc == presc_max(ch_q[c].div)) begin
          ch_d[c]       = step_duty(ch_q[c]);
          ch_d[c].presc = 16'd0;
        end else begin
          ch_d[c].presc = ch_q[c].presc + 16'd1;
        end
      end
    end
  end

  // Channel registers and the configuration shadow slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the channel array is only two entries of control state, so it is
      // reset explicitly; large data storage would normally be left unreset.
      for (int c = 0; c < 2; c++) begin
        ch_q[c] <= '0;
      end
      shadow      <= '0;
      shadow_full <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        ch_q[c] <= ch_d[c];
      end
      if (apply) begin
        shadow_full <= 1'b0;
      end else if (cfg_valid && cfg_ready) begin
        shadow      <= '{chan: cfg_chan, mode: mode_e'(cfg_mode),
                         div: cfg_div, duty: cfg_duty};
        shadow_full <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scheduler FSM
  // ---------------------------------------------------------------------------
  // All transitions happen on the boundary edge. Dropping enable takes
  // priority over a dwell-driven channel switch.
  always_comb begin
    state_d     = state;
    dwell_cnt_d = dwell_cnt;
    if (boundary) begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state_d     = ST_RUN_A;
            dwell_cnt_d = dwell_load;
          end
        end
        ST_RUN_A, ST_RUN_B: begin
          if (!enable) begin
            state_d = ST_IDLE;
          end else if (dwell_cnt == '0) begin
            state_d     = (state == ST_RUN_A) ? ST_RUN_B : ST_RUN_A;
            dwell_cnt_d = dwell_load;
          end else begin
            dwell_cnt_d = dwell_cnt - DWELL_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output selection uses next-cycle values so the first cycle of a period
  // (cnt == 0) already reflects the new state, channel and duty.
  always_comb begin
    case (state_d)
      ST_RUN_A: chan_d = 1'b0;
      ST_RUN_B: chan_d = 1'b1;
      default:  chan_d = active_chan;   // idle keeps the last channel
    endcase
    pwm_d = (state_d != ST_IDLE) &&
            (cnt_d < (chan_d ? ch_d[1].duty : ch_d[0].duty));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      dwell_cnt   <= '0;
      active_chan <= 1'b0;
      pwm_out     <= 1'b0;
    end else begin
      state       <= state_d;
      dwell_cnt   <= dwell_cnt_d;
      active_chan <= chan_d;
      pwm_out     <= pwm_d;
    end
  end

endmodule

// File: tb/tb_pwm_sweep_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pwm_sweep_scheduler
//
// Directed bench with a period-indexed scoreboard. The stimulus process
// pushes expected per-period observations (high-cycle count, active channel,
// duties) tagged with the period number in which they must hold. A monitor
// accumulates pwm_out over each 256-cycle period and, on every period_stb,
// pops and compares the entries tagged for that period.
// Periods are numbered from 1 after each reset release.
// -----------------------------------------------------------------------------
module tb_pwm_sweep_scheduler;

  localparam int K_HIGH  = 0;
  localparam int K_CHAN  = 1;
  localparam int K_DUTY0 = 2;
  localparam int K_DUTY1 = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] dwell;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_chan;
  logic [1:0]  cfg_mode;
  logic [3:0]  cfg_div;
  logic [7:0]  cfg_duty;
  logic        pwm_out;
  logic        period_stb;
  logic        active_chan;
  logic [7:0]  duty0;
  logic [7:0]  duty1;

  always #5 clk = ~clk;

  pwm_sweep_scheduler #(.DWELL_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .dwell       (dwell),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_chan    (cfg_chan),
    .cfg_mode    (cfg_mode),
    .cfg_div     (cfg_div),
    .cfg_duty    (cfg_duty),
    .pwm_out     (pwm_out),
    .period_stb  (period_stb),
    .active_chan (active_chan),
    .duty0       (duty0),
    .duty1       (duty1)
  );

  int n_checks = 0;
  int n_err    = 0;
  int pcount   = 0;   // period strobes seen since the last reset release

  typedef struct {
    int pidx;
    int kind;
    int value;
  } exp_t;

  exp_t sb[$];

  function automatic string kind_name(input int k);
    case (k)
      K_HIGH:  return "high_cycles";
      K_CHAN:  return "active_chan";
      K_DUTY0: return "duty0";
      default: return "duty1";
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_at(input int p, input int k, input int v);
    exp_t e;
    e.pidx  = p;
    e.kind  = k;
    e.value = v;
    sb.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: samples on the falling edge, away from the active edge.
  // ---------------------------------------------------------------------------
  initial begin
    int   acc;
    int   since;
    int   n;
    int   act;
    logic prev_chan;
    logic prev_stb;
    acc = 0; since = 0; prev_chan = 1'b0; prev_stb = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pcount    = 0;
        acc       = 0;
        since     = 0;
        prev_chan = 1'b0;
        prev_stb  = 1'b0;
      end else begin
        since++;
        if (pwm_out) acc++;
        if (active_chan !== prev_chan)
          check("chan_switch_on_boundary", int'(prev_stb), 1);
        prev_chan = active_chan;
        prev_stb  = period_stb;
        if (period_stb) begin
          n = pcount + 1;
          if (n > 1) check("stb_spacing", since, 256);
          for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].pidx == n) begin
              case (sb[i].kind)
                K_HIGH:  act = acc;
                K_CHAN:  act = int'(active_chan);
                K_DUTY0: act = int'(duty0);
                default: act = int'(duty1);
              endcase
              check($sformatf("p%0d_%s", n, kind_name(sb[i].kind)), act, sb[i].value);
              sb.delete(i);
            end else if (sb[i].pidx < n) begin
              check($sformatf("missed_p%0d_%s", sb[i].pidx, kind_name(sb[i].kind)),
                    n, sb[i].pidx);
              sb.delete(i);
            end
          end
          pcount = n;
          acc    = 0;
          since  = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns at cnt == 0 of period target+1.
  task automatic wait_period(input int target);
    int guard;
    guard = 0;
    while (pcount < target && guard < 20000) begin
      tick();
      guard++;
    end
    check($sformatf("reach_period_%0d", target), pcount, target);
  endtask

  // Issue one config write; vis = first period in which it is visible.
  task automatic do_cfg(input logic ch, input logic [1:0] mode, input logic [3:0] div,
                        input logic [7:0] duty, output int vis);
    int   guard;
    logic in_bnd;
    int   k;
    cfg_chan  = ch;
    cfg_mode  = mode;
    cfg_div   = div;
    cfg_duty  = duty;
    cfg_valid = 1'b1;
    guard = 0;
    while (!cfg_ready && guard < 1000) begin
      tick();
      guard++;
    end
    check("cfg_ready_wait", int'(cfg_ready), 1);
    in_bnd = period_stb;
    k      = pcount;
    tick();
    cfg_valid = 1'b0;
    vis = in_bnd ? k + 3 : k + 2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    int   v;
    int   vb;
    int   vc;
    int   waited;
    int   k;
    logic [7:0] d0;

    rst_n     = 1'b0;
    enable    = 1'b1;
    dwell     = 16'd1000;
    cfg_valid = 1'b0;
    cfg_chan  = 1'b0;
    cfg_mode  = 2'b00;
    cfg_div   = 4'd0;
    cfg_duty  = 8'd0;
    repeat (3) tick();

    // Reset values.
    check("rst_pwm_out", int'(pwm_out), 0);
    check("rst_period_stb", int'(period_stb), 0);
    check("rst_active_chan", int'(active_chan), 0);
    check("rst_duty0", int'(duty0), 0);
    check("rst_duty1", int'(duty1), 0);
    rst_n = 1'b1;
    check("ready_after_reset", int'(cfg_ready), 1);

    // Hold duty 64 on channel 0: 64 of 256 cycles high once running.
    do_cfg(1'b0, 2'b00, 4'd0, 8'd64, v);
    expect_at(v - 1, K_HIGH, 0);
    expect_at(v - 1, K_DUTY0, 0);
    for (int p = v; p < v + 2; p++) begin
      expect_at(p, K_HIGH, 64);
      expect_at(p, K_CHAN, 0);
      expect_at(p, K_DUTY0, 64);
      expect_at(p, K_DUTY1, 0);
    end
    wait_period(v + 1);

    // Ramp channel 0 every period from 254: 254, 255, 0, 1.
    do_cfg(1'b0, 2'b01, 4'd0, 8'd254, vb);
    expect_at(vb,     K_DUTY0, 254);
    expect_at(vb + 1, K_DUTY0, 255);
    expect_at(vb + 2, K_DUTY0, 0);
    expect_at(vb + 3, K_DUTY0, 1);
    expect_at(vb,     K_HIGH, 254);
    expect_at(vb + 1, K_HIGH, 255);
    expect_at(vb + 2, K_HIGH, 0);
    expect_at(vb + 3, K_HIGH, 1);

    // Triangle on channel 1, one step every 4 periods, from 253. This write
    // also has to wait for the slot freed by the previous one.
    do_cfg(1'b1, 2'b10, 4'd2, 8'd253, vc);
    expect_at(vc,      K_DUTY1, 253);
    expect_at(vc + 3,  K_DUTY1, 253);
    expect_at(vc + 4,  K_DUTY1, 254);
    expect_at(vc + 8,  K_DUTY1, 255);
    expect_at(vc + 12, K_DUTY1, 254);
    expect_at(vc + 16, K_DUTY1, 253);
    for (int p = vc; p <= vc + 16; p += 4) begin
      d0 = 8'(254 + p - vb);
      expect_at(p, K_DUTY0, int'(d0));
      expect_at(p, K_HIGH, int'(d0));
      expect_at(p, K_CHAN, 0);
    end
    wait_period(vc + 16);

    // Channel alternation with dwell = 2, then dwell = 0.
    dwell = 16'd2;
    do_reset();
    do_cfg(1'b0, 2'b00, 4'd0, 8'd32, v);
    do_cfg(1'b1, 2'b00, 4'd0, 8'd200, v);
    expect_at(2, K_CHAN, 0);  expect_at(2, K_HIGH, 32);
    expect_at(3, K_CHAN, 0);  expect_at(3, K_HIGH, 32);
    expect_at(4, K_CHAN, 1);  expect_at(4, K_HIGH, 200);
    expect_at(5, K_CHAN, 1);  expect_at(5, K_HIGH, 200);
    expect_at(6, K_CHAN, 0);  expect_at(6, K_HIGH, 32);
    expect_at(7, K_CHAN, 0);  expect_at(7, K_HIGH, 32);
    expect_at(8, K_CHAN, 1);  expect_at(8, K_HIGH, 200);
    expect_at(9, K_CHAN, 1);  expect_at(9, K_HIGH, 200);
    wait_period(7);
    dwell = 16'd0;  // takes effect at the next channel entry (boundary 9)
    expect_at(10, K_CHAN, 0); expect_at(10, K_HIGH, 32);
    expect_at(11, K_CHAN, 1); expect_at(11, K_HIGH, 200);
    expect_at(12, K_CHAN, 0); expect_at(12, K_HIGH, 32);
    expect_at(13, K_CHAN, 1); expect_at(13, K_HIGH, 200);
    wait_period(13);

    // Write captured in a boundary cycle; second write held until ready.
    waited = 0;
    while (!period_stb && waited < 300) begin
      tick();
      waited++;
    end
    check("found_boundary_cycle", int'(period_stb), 1);
    k = pcount;
    cfg_chan  = 1'b0;
    cfg_mode  = 2'b00;
    cfg_div   = 4'd0;
    cfg_duty  = 8'd100;
    cfg_valid = 1'b1;
    tick();
    check("ready_drop_after_capture", int'(cfg_ready), 0);
    expect_at(k + 2, K_DUTY0, 32);
    expect_at(k + 3, K_DUTY0, 100);
    expect_at(k + 3, K_DUTY1, 200);
    expect_at(k + 4, K_DUTY1, 50);
    expect_at(k + 3, K_HIGH, 100);
    expect_at(k + 4, K_HIGH, 50);
    cfg_chan = 1'b1;
    cfg_duty = 8'd50;
    waited = 0;
    while (!cfg_ready && waited < 600) begin
      tick();
      waited++;
    end
    check("second_write_wait_cycles", waited, 256);
    tick();
    cfg_valid = 1'b0;

    // Drop enable mid-period: finish the period, then park low.
    wait_period(17);
    repeat (100) tick();
    enable = 1'b0;
    expect_at(18, K_HIGH, 100); expect_at(18, K_CHAN, 0);
    expect_at(19, K_HIGH, 0);   expect_at(19, K_CHAN, 0);
    expect_at(20, K_HIGH, 0);   expect_at(20, K_CHAN, 0);
    wait_period(18);
    check("idle_low_from_cnt0", int'(pwm_out), 0);

    // Channels keep sweeping while idle.
    do_cfg(1'b1, 2'b01, 4'd0, 8'd10, v);
    expect_at(v,     K_DUTY1, 10);
    expect_at(v + 1, K_DUTY1, 11);
    expect_at(v + 2, K_DUTY1, 12);
    expect_at(v + 1, K_HIGH, 0);
    expect_at(v + 2, K_HIGH, 0);
    wait_period(22);
    enable = 1'b1;
    expect_at(23, K_HIGH, 0);
    expect_at(24, K_HIGH, 100);
    expect_at(24, K_CHAN, 0);
    wait_period(24);

    // Reset mid-period with a write pending: outputs clear at once and the
    // pending write is dropped.
    do_cfg(1'b0, 2'b00, 4'd0, 8'd77, v);
    repeat (4) tick();
    check("pre_reset_pwm_high", int'(pwm_out), 1);
    check("pre_reset_chan", int'(active_chan), 1);
    enable = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("async_rst_pwm_out", int'(pwm_out), 0);
    check("async_rst_period_stb", int'(period_stb), 0);
    check("async_rst_active_chan", int'(active_chan), 0);
    check("async_rst_duty0", int'(duty0), 0);
    check("async_rst_duty1", int'(duty1), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    check("ready_after_midrun_reset", int'(cfg_ready), 1);
    expect_at(1, K_DUTY0, 0);
    expect_at(2, K_DUTY0, 0);
    expect_at(2, K_HIGH, 0);
    wait_period(2);

    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
